row_read_arbiter: RTL

- Round-robin scheduler that shares the single 16-row, 32-bit row-read unit among NREQ requesters.
- Each requester posts a row number; the arbiter issues one-cycle read strobes to the read unit, one outstanding read at a time.
- Returns the 32-bit row data to the winning requester, or an error response if the read unit never answers within TIMEOUT cycles.
- Sits between requesting datapath blocks and the read unit (read unit ports: clk, row_num[3:0], input_valid, output_valid, out[31:0]).

---
 rtl/row_read_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/row_read_arbiter.sv
// row_read_arbiter: round-robin scheduler that shares one 16-row, 32-bit
// row-read unit among NREQ requesters. It keeps one read outstanding at a
// time and returns either the row data or a timeout error to the winner.
module row_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_row,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              rd_valid,
  output logic [3:0]        rd_row,
  input  logic              rd_out_valid,
  input  logic [31:0]       rd_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [NREQ-1:0]        pending_q, pending_d;
  logic [NREQ-1:0][3:0]   row_buf_q, row_buf_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic [7:0]             timer_q, timer_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [3:0]             rd_row_q, rd_row_d;
  logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic                   resp_err_q, resp_err_d;

  logic                   found;
  logic [IW-1:0]          next_grant;
  logic [IW-1:0]          cand;

  assign req_ready  = ~pending_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign rd_valid   = rd_valid_q;
  assign rd_row     = rd_row_q;

  // Capture new requests into their one-deep slot and retire the served one.
  always_comb begin
    pending_d = pending_q;
    row_buf_d = row_buf_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        row_buf_d[i] = req_row[4*i +: 4];
      end
    end
    if (state_q == S_RESP) begin
      pending_d[grant_q] = 1'b0;
    end
  end

  // Round-robin search: first pending requester after the last one served.
  always_comb begin
    found      = 1'b0;
    next_grant = last_grant_q;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NREQ);
      if (!found && pending_q[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  // Next-state and registered-output logic for the issue/wait/respond cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    rd_valid_d   = rd_valid_q;
    rd_row_d     = rd_row_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d    = next_grant;
          rd_row_d   = row_buf_q[next_grant];
          rd_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_valid_d = 1'b0;
        timer_d    = 8'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (rd_out_valid) begin
          resp_data_d  = rd_out;
          resp_err_d   = 1'b0;
          resp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
          state_d      = S_RESP;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          resp_data_d  = 32'd0;
          resp_err_d   = 1'b1;
          resp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset clears everything and gives requester 0 first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      row_buf_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= IW'(NREQ - 1);
      timer_q      <= 8'd0;
      rd_valid_q   <= 1'b0;
      rd_row_q     <= 4'd0;
      resp_valid_q <= '0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      row_buf_q    <= row_buf_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      rd_valid_q   <= rd_valid_d;
      rd_row_q     <= rd_row_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
